conv_unit: RTL and testbench

Streaming 3×3 image convolution engine for the pixel-processing path. It accepts one raster-scanned pixel per enabled clock and buffers two image rows internally. It applies a fixed 3×3 smoothing kernel (1 2 1 / 2 4 2 / 1 2 1, normalised by 16) and emits one filtered pixel per complete window. It sits between the bitmap/pixel source and the downstream pixel sink; there is no back-pressure.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_line_buffer.sv | 36 +++
 rtl/conv_unit.sv | 118 +++++++++++
 tb/tb_conv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 smoothing convolution path.
package conv_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ACC_GROWTH     = 4;
    localparam int unsigned NORM_SHIFT     = 4;
    localparam int unsigned ROUND_CONST    = 8;

    // Smoothing kernel, row 0 is the oldest (topmost) image row.
    localparam int unsigned KERNEL [3][3] = '{
        '{1, 2, 1},
        '{2, 4, 2},
        '{1, 2, 1}
    };

    // Accumulator width needed for a kernel whose weights sum to 16.
    function automatic int unsigned acc_width(input int unsigned dw);
        return dw + ACC_GROWTH;
    endfunction

    // Kernel weights are powers of two, so each product becomes a left shift.
    function automatic int unsigned weight_shift(input int unsigned w);
        int unsigned sh;
        sh = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) == w) sh = i;
        end
        return sh;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: a circular RAM whose output is the sample written DEPTH shifts ago.
module conv_line_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_shift_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_ptr;

    // Reading the slot before it is overwritten yields the sample from one row earlier.
    assign o_data = r_mem[r_ptr];

    // Storage is written only on shift; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_shift_en) r_mem[r_ptr] <= i_data;
    end

    // Wrapping write/read pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_shift_en) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) r_ptr <= '0;
            else                            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/conv_unit.sv
// Streaming 3x3 smoothing filter: two line buffers, a 3x3 window, shift-add tree, registered output.
module conv_unit
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int ACC_W = int'(acc_width(DATA_WIDTH));

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_win_valid;
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    logic [DATA_WIDTH-1:0] w_lb1_out;
    logic [DATA_WIDTH-1:0] w_lb2_out;
    logic [ACC_W-1:0]      w_sum;
    logic [ACC_W-1:0]      w_rounded;
    logic [DATA_WIDTH-1:0] w_pix;

    // lb1 delivers the row above the input; lb2 chains off it for two rows above.
    conv_line_buffer #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_shift_en (valid_in),
        .i_data     (data_in),
        .o_data     (w_lb1_out)
    );

    conv_line_buffer #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb2 (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_shift_en (valid_in),
        .i_data     (w_lb1_out),
        .o_data     (w_lb2_out)
    );

    // Raster position of the pixel being accepted; wraps per row and per frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (r_col == COL_W'(IMG_WIDTH - 1)) begin
                r_col <= '0;
                if (r_row == ROW_W'(IMG_HEIGHT - 1)) r_row <= '0;
                else                                 r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Window is complete only when the accepted pixel closes a full 3x3 in this frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_win_valid <= 1'b0;
        else      r_win_valid <= valid_in && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    end

    // Shift the window one column left; column 2 takes the newest column.
    always_ff @(posedge Clk) begin
        if (valid_in) begin
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb2_out;
            r_win[1][2] <= w_lb1_out;
            r_win[2][2] <= data_in;
        end
    end

    // Weighted sum as shifts and adds, then round-to-nearest normalisation.
    always_comb begin
        w_sum = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_sum = w_sum + (ACC_W'(r_win[r][c]) << weight_shift(KERNEL[r][c]));
            end
        end
        w_rounded = w_sum + ACC_W'(ROUND_CONST);
        w_pix     = DATA_WIDTH'(w_rounded >> NORM_SHIFT);
    end

    // Output registers: one-cycle valid pulse, data held between outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= r_win_valid;
            if (r_win_valid) r_data_out <= w_pix;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_conv_unit.sv
// Self-checking bench for conv_unit on an 8x8 image with a frame-level reference model.
module tb_conv_unit;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;

    logic          Clk;
    logic          Rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] data_out;
    logic          valid_out;

    int vectors;
    int miscompares;

    conv_unit #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (posedge, model-only state) ----------------
    typedef struct { int val; int due; } exp_t;
    exp_t exp_q[$];
    int   flush_to;
    int   cyc;
    int   mrow, mcol;
    int   img [H][W];

    always @(posedge Clk) begin
        int sum, wgt;
        cyc++;
        if (!Rst) begin
            mrow     = 0;
            mcol     = 0;
            flush_to = exp_q.size();
        end else if (valid_in) begin
            img[mrow][mcol] = int'(data_in);
            if (mrow >= 2 && mcol >= 2) begin
                sum = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        wgt = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                        sum += wgt * img[mrow - 1 + dr][mcol - 1 + dc];
                    end
                exp_q.push_back('{val: (sum + 8) / 16, due: cyc + 1});
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow++;
                if (mrow == H) mrow = 0;
            end
        end
    end

    // ---------------- output monitor (negedge) ----------------
    int rd_idx;
    int out_count;
    int got_log[$];
    int last_out;

    always @(negedge Clk) begin
        if (rd_idx < flush_to) rd_idx = flush_to;
        if (!Rst) begin
            check("rst_valid_out", int'(valid_out), 0);
            check("rst_data_out", int'(data_out), 0);
            last_out = 0;
        end else if (valid_out) begin
            if (rd_idx >= exp_q.size()) begin
                check("spurious_valid", 1, 0);
            end else begin
                check("pixel", int'(data_out), exp_q[rd_idx].val);
                check("latency_cycle", cyc, exp_q[rd_idx].due);
                rd_idx++;
            end
            last_out = int'(data_out);
            out_count++;
            got_log.push_back(int'(data_out));
        end else begin
            check("hold_data", int'(data_out), last_out);
            if (rd_idx < exp_q.size() && exp_q[rd_idx].due < cyc) begin
                check("missing_valid", 0, 1);
                rd_idx++;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'h80;
            1:       return 8'hFF;
            2:       return 8'h00;
            3:       return (r == 4 && c == 4) ? 8'hFF : 8'h00;
            4:       return DW'(r * W + c);
            default: return DW'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_frame(input int kind, input int gapmax, input int npix);
        int gaps;
        for (int i = 0; i < npix; i++) begin
            gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (gaps) begin
                @(posedge Clk); #2;
                valid_in = 1'b0;
                data_in  = DW'($urandom_range(0, 255));
            end
            @(posedge Clk); #2;
            valid_in = 1'b1;
            data_in  = pix(kind, i / W, i % W);
        end
        @(posedge Clk); #2;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rd_idx < exp_q.size() && n < 20) begin
            @(posedge Clk); #2;
            n++;
        end
        check("drain_pending", exp_q.size() - rd_idx, 0);
        repeat (3) @(posedge Clk);
        #2;
    endtask

    initial begin
        int base;
        int imp_ref[36];

        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b0;
        valid_in    = 1'b0;
        data_in     = '0;
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #2;

        // Constant 0x80 frame, continuous valid.
        base = out_count;
        send_frame(0, 0, W * H);
        drain();
        check("const80_count", out_count - base, 36);
        check("const80_first", got_log[base], 8'h80);

        // All 0xFF frame.
        base = out_count;
        send_frame(1, 0, W * H);
        drain();
        check("ff_count", out_count - base, 36);
        check("ff_last", got_log[base + 35], 8'hFF);

        // Impulse, continuous valid.
        base = out_count;
        send_frame(3, 0, W * H);
        drain();
        check("imp_count", out_count - base, 36);
        check("imp_center", got_log[base + 21], 8'h40);
        check("imp_up",     got_log[base + 15], 8'h20);
        check("imp_left",   got_log[base + 20], 8'h20);
        check("imp_diag",   got_log[base + 14], 8'h10);
        check("imp_corner", got_log[base + 0],  8'h00);
        for (int i = 0; i < 36; i++) imp_ref[i] = got_log[base + i];

        // Same impulse with random idle gaps.
        base = out_count;
        send_frame(3, 3, W * H);
        drain();
        check("imp_gap_count", out_count - base, 36);
        for (int i = 0; i < 36; i++) check("imp_gap_seq", got_log[base + i], imp_ref[i]);

        // Back-to-back frames: all 0xFF then all 0x00.
        base = out_count;
        send_frame(1, 0, W * H);
        send_frame(2, 0, W * H);
        drain();
        check("b2b_count", out_count - base, 72);
        check("b2b_f1_last",  got_log[base + 35], 8'hFF);
        check("b2b_f2_first", got_log[base + 36], 8'h00);

        // Random pixels with random gaps.
        base = out_count;
        send_frame(5, 2, W * H);
        drain();
        check("rand_count", out_count - base, 36);

        // Reset mid row 3, then a fresh ramp frame.
        send_frame(4, 0, 3 * W + 4);
        @(posedge Clk); #2;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        base = out_count;
        send_frame(4, 1, W * H);
        drain();
        check("ramp_count", out_count - base, 36);
        check("ramp_first", got_log[base], 8'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
